key_filter: RTL and testbench
=============================

# key_filter

Multi-key input conditioner that sits directly upstream of the counter/display blocks. It takes raw, asynchronous, bouncing push-button levels and turns them into clean per-key outputs: a debounced level, a one-cycle press pulse, a one-cycle release pulse, and a long-press auto-repeat pulse. Downstream blocks such as run/stop toggles and up/down counters use these pulses directly as single-cycle enables in the `clk` domain.

## Interface
- `N`, 4: number of independent keys.
- `DEB_CNT`, 20: debounce length in `clk` cycles; legal range ≥ 1.
- `LONG_CNT`, 1000: cycles from `key_pulse` to the first `key_repeat`; legal range ≥ 1.
- `REP_CNT`, 200: cycles between subsequent `key_repeat` pulses; legal range ≥ 1.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst_n`  input  1  reset, asynchronous assert and active-low; asynchronous active-low reset, single clock domain.
- `key`  input  N  raw key levels, 1 = pressed, asynchronous to `clk`.
- `key_state`  output  N  debounced level per key.
- `key_pulse`  output  N  one-cycle strobe on an accepted press.
- `key_release`  output  N  one-cycle strobe on an accepted release.
- `key_repeat`  output  N  one-cycle strobe while a key is held past `LONG_CNT`.

## Operation
- Each key passes through a 2-flop synchronizer (reset value 0); the synchronized bit is `s`. All keys are fully independent.
- Per-key FSM states: UP, DN_FILT, DOWN, UP_FILT. Reset state is UP.
- Per-key debounce counter `cnt`, width $clog2(DEB_CNT+1).
- Per-key repeat counter `rcnt`, width $clog2(max(LONG_CNT,REP_CNT)+1).
- UP:
  - If `s`=1: go to DN_FILT and set `cnt`=0.
- DN_FILT:
  - If `s`=0: return to UP; no output.
  - Else if `cnt`=DEB_CNT-1: go to DOWN, assert `key_pulse` for one cycle, set `key_state`=1, load `rcnt`=LONG_CNT-1.
  - Else: `cnt`+1.
- DOWN:
  - If `s`=0: go to UP_FILT and set `cnt`=0. `rcnt` freezes.
  - Else if `rcnt`=0: assert `key_repeat` for one cycle and reload `rcnt`=REP_CNT-1.
  - Else: `rcnt`-1.
- UP_FILT:
  - If `s`=1: return to DOWN. `rcnt` resumes from its frozen value; no pulse.
  - Else if `cnt`=DEB_CNT-1: go to UP, assert `key_release` for one cycle, set `key_state`=0.
  - Else: `cnt`+1.
  - No `key_repeat` is issued while in UP_FILT.
- Acceptance rule: a level change is accepted only after DEB_CNT+1 consecutive `clk` edges with the new value on `s`. A run of DEB_CNT edges or fewer is rejected and produces no output.
- All outputs are registered. `key_pulse`, `key_release` and `key_repeat` are mutually exclusive per key in any cycle. Different keys may pulse in the same cycle.
- Reset asserted mid-operation: every FSM goes to UP and all counters, synchronizers and outputs clear immediately. No release pulse is emitted.
- Key held while reset is released: the key is treated as a fresh press and produces `key_pulse` after the normal latency.

## Timing
- Reset values: `key_state`=0, `key_pulse`=0, `key_release`=0, `key_repeat`=0 for every key.
- Edge numbering: edge 1 is the first `clk` edge at which `key` is sampled high.
  - `s` is high after edge 2.
  - DN_FILT is entered at edge 3.
  - `key_pulse` and `key_state` rise after edge DEB_CNT+3.
- Release latency is symmetric: `key_release` is high and `key_state` falls after edge DEB_CNT+3, where edge 1 is the first edge sampling `key` low.
- Repeat timing, with `key_pulse` high in cycle P:
  - First `key_repeat` in cycle P+LONG_CNT.
  - Then `key_repeat` every REP_CNT cycles while `s` stays 1.
- Every pulse output is exactly one `clk` cycle wide.

## Test plan
Configuration for all scenarios: N=2, DEB_CNT=4, LONG_CNT=16, REP_CNT=5.
- Reset: drive `rst_n`=0 with `key`=2'b11 → all outputs 0. Release `rst_n` → `key_pulse`=2'b11 after edge 7, both `key_state` bits 1.
- Glitch rejection: `key[0]` high for 4 edges, then low → no pulses, `key_state`=0. High for 5 edges → `key_pulse[0]` after edge 7 and, 7 edges after the fall, `key_release[0]`.
- Bounce: `key[0]` toggles 1,0,1,1,0,1 then stays 1 → exactly one `key_pulse[0]`, 7 edges after the last rising sample.
- Long press: hold `key[1]` for 40 cycles after `key_pulse[1]` in cycle P → `key_repeat[1]` in cycles P+16, P+21, P+26, P+31, P+36. Then release → one `key_release[1]`, and no repeat appears during UP_FILT.
- Independence: `key[0]` pressed, `key[1]` pressed 2 cycles later → `key_pulse[0]` and `key_pulse[1]` two cycles apart; neither key affects the other's timing.
- Reset mid-hold: assert `rst_n`=0 while `key_state[0]`=1 and in repeat mode → all outputs 0 immediately and no `key_release`. After deassertion with the key still held → a new `key_pulse[0]` at edge 7.

Source files
------------

// File: rtl/key_filter_if.sv
// Key-conditioner bundle: raw key levels in, debounced level and strobes out.
// fsm_state carries each key's 2-bit FSM state (key i at bits [2i+1:2i]).
interface key_filter_if #(
  parameter int N = 4
);
  logic [N-1:0]   key;
  logic [N-1:0]   key_state;
  logic [N-1:0]   key_pulse;
  logic [N-1:0]   key_release;
  logic [N-1:0]   key_repeat;
  logic [2*N-1:0] fsm_state;

  modport master (
    output key,
    input  key_state, key_pulse, key_release, key_repeat, fsm_state
  );

  modport slave (
    input  key,
    output key_state, key_pulse, key_release, key_repeat, fsm_state
  );
endinterface

// File: rtl/key_filter.sv
// Per-key debounce with registered press/release strobes and long-press auto-repeat.
// Keys are fully independent; each has a 2-flop synchronizer and a 4-state FSM.
module key_filter #(
  parameter int N        = 4,
  parameter int DEB_CNT  = 20,
  parameter int LONG_CNT = 1000,
  parameter int REP_CNT  = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  key_filter_if.slave kif
);
  localparam int CW   = $clog2(DEB_CNT + 1);
  localparam int RMAX = (LONG_CNT > REP_CNT) ? LONG_CNT : REP_CNT;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(DEB_CNT - 1);
  localparam logic [RW-1:0] LONG_LOAD = RW'(LONG_CNT - 1);
  localparam logic [RW-1:0] REP_LOAD  = RW'(REP_CNT - 1);

  typedef enum logic [1:0] {
    UP      = 2'd0,
    DN_FILT = 2'd1,
    DOWN    = 2'd2,
    UP_FILT = 2'd3
  } state_t;

  logic [N-1:0]  sync1_q, sync2_q;
  logic [N-1:0]  s;
  state_t        state_q [N];
  state_t        state_d [N];
  logic [CW-1:0] cnt_q   [N];
  logic [CW-1:0] cnt_d   [N];
  logic [RW-1:0] rcnt_q  [N];
  logic [RW-1:0] rcnt_d  [N];
  logic [N-1:0]  key_state_q, key_state_d;
  logic [N-1:0]  pulse_q, pulse_d;
  logic [N-1:0]  release_q, release_d;
  logic [N-1:0]  repeat_q, repeat_d;

  assign s = sync2_q;

  // State register: reset clears synchronizers too, so a key held through
  // reset is seen as a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      key_state_q <= '0;
      pulse_q     <= '0;
      release_q   <= '0;
      repeat_q    <= '0;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= UP;
        cnt_q[i]   <= '0;
        rcnt_q[i]  <= '0;
      end
    end else begin
      sync1_q     <= kif.key;
      sync2_q     <= sync1_q;
      key_state_q <= key_state_d;
      pulse_q     <= pulse_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        rcnt_q[i]  <= rcnt_d[i];
      end
    end
  end

  // Next-state logic
  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        UP:      if (s[i]) state_d[i] = DN_FILT;
        DN_FILT: if (!s[i]) state_d[i] = UP;
                 else if (cnt_q[i] == CNT_LAST) state_d[i] = DOWN;
        DOWN:    if (!s[i]) state_d[i] = UP_FILT;
        UP_FILT: if (s[i]) state_d[i] = DOWN;
                 else if (cnt_q[i] == CNT_LAST) state_d[i] = UP;
        default: state_d[i] = UP;
      endcase
    end
  end

  // Output / counter logic. rcnt is untouched outside DN_FILT->DOWN and DOWN,
  // so a bounce back from UP_FILT resumes the repeat timing where it stopped.
  always_comb begin
    key_state_d = key_state_q;
    pulse_d     = '0;
    release_d   = '0;
    repeat_d    = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i]  = cnt_q[i];
      rcnt_d[i] = rcnt_q[i];
      case (state_q[i])
        UP: if (s[i]) cnt_d[i] = '0;
        DN_FILT: begin
          if (s[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
              pulse_d[i]     = 1'b1;
              key_state_d[i] = 1'b1;
              rcnt_d[i]      = LONG_LOAD;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
        DOWN: begin
          if (!s[i]) begin
            cnt_d[i] = '0;
          end else if (rcnt_q[i] == '0) begin
            repeat_d[i] = 1'b1;
            rcnt_d[i]   = REP_LOAD;
          end else begin
            rcnt_d[i] = rcnt_q[i] - 1'b1;
          end
        end
        UP_FILT: begin
          if (!s[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
              release_d[i]   = 1'b1;
              key_state_d[i] = 1'b0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign kif.key_state   = key_state_q;
  assign kif.key_pulse   = pulse_q;
  assign kif.key_release = release_q;
  assign kif.key_repeat  = repeat_q;

  for (genvar g = 0; g < N; g++) begin : g_dbg
    assign kif.fsm_state[2*g +: 2] = state_q[g];
  end
endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter with N=2, DEB_CNT=4, LONG_CNT=16, REP_CNT=5.
// Outputs are compared as {pulse, release, repeat, state} at #1 after each edge.
module tb_key_filter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [1:0] ep, er, et, es;

  key_filter_if #(.N(2)) kif ();

  key_filter #(
    .N(2), .DEB_CNT(4), .LONG_CNT(16), .REP_CNT(5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    kif.key = 2'b11;
    repeat (3) tick();
    total++;
    if ({kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state, kif.fsm_state} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs: got %b, want 0",
               {kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state, kif.fsm_state});
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      ep = (e == 7) ? 2'b11 : 2'b00;
      er = 2'b00;
      et = 2'b00;
      es = (e >= 7) ? 2'b11 : 2'b00;
      total++;
      if ({kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state} !== {ep, er, et, es}) begin
        bad++;
        $display("FAIL reset_press edge %0d: got %b, want %b", e,
                 {kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state}, {ep, er, et, es});
      end
    end
    kif.key = 2'b00;
    for (int e = 1; e <= 8; e++) begin
      tick();
      ep = 2'b00;
      er = (e == 7) ? 2'b11 : 2'b00;
      et = 2'b00;
      es = (e >= 7) ? 2'b00 : 2'b11;
      total++;
      if ({kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state} !== {ep, er, et, es}) begin
        bad++;
        $display("FAIL reset_release edge %0d: got %b, want %b", e,
                 {kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state}, {ep, er, et, es});
      end
    end
  endtask

  task automatic test_glitch();
    // four high samples must be rejected
    for (int e = 1; e <= 14; e++) begin
      kif.key = (e <= 4) ? 2'b01 : 2'b00;
      tick();
      total++;
      if ({kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state} !== 8'h00) begin
        bad++;
        $display("FAIL glitch_reject edge %0d: got %b, want 0", e,
                 {kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state});
      end
    end
    // five high samples are accepted; release follows the fall by 7 edges
    for (int e = 1; e <= 14; e++) begin
      kif.key = (e <= 5) ? 2'b01 : 2'b00;
      tick();
      ep = (e == 7) ? 2'b01 : 2'b00;
      er = (e == 12) ? 2'b01 : 2'b00;
      et = 2'b00;
      es = (e >= 7 && e < 12) ? 2'b01 : 2'b00;
      total++;
      if ({kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state} !== {ep, er, et, es}) begin
        bad++;
        $display("FAIL glitch_accept edge %0d: got %b, want %b", e,
                 {kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state}, {ep, er, et, es});
      end
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    pat = 6'b101101; // bit e-1 is the level sampled at edge e: 1,0,1,1,0,1
    for (int e = 1; e <= 16; e++) begin
      kif.key = {1'b0, (e <= 6) ? pat[e-1] : 1'b1};
      tick();
      ep = (e == 12) ? 2'b01 : 2'b00;
      er = 2'b00;
      et = 2'b00;
      es = (e >= 12) ? 2'b01 : 2'b00;
      total++;
      if ({kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state} !== {ep, er, et, es}) begin
        bad++;
        $display("FAIL bounce edge %0d: got %b, want %b", e,
                 {kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state}, {ep, er, et, es});
      end
    end
    kif.key = 2'b00;
    repeat (12) tick();
  endtask

  task automatic test_long_press();
    // pulse after edge 7; release timed so rcnt has reached 0 when UP_FILT is entered
    for (int e = 1; e <= 58; e++) begin
      kif.key = (e <= 45) ? 2'b10 : 2'b00;
      tick();
      ep = (e == 7) ? 2'b10 : 2'b00;
      er = (e == 52) ? 2'b10 : 2'b00;
      et = (e == 23 || e == 28 || e == 33 || e == 38 || e == 43) ? 2'b10 : 2'b00;
      es = (e >= 7 && e < 52) ? 2'b10 : 2'b00;
      total++;
      if ({kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state} !== {ep, er, et, es}) begin
        bad++;
        $display("FAIL long_press edge %0d: got %b, want %b", e,
                 {kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state}, {ep, er, et, es});
      end
    end
  endtask

  task automatic test_independence();
    for (int e = 1; e <= 12; e++) begin
      kif.key = (e <= 2) ? 2'b01 : 2'b11;
      tick();
      ep = {e == 9, e == 7};
      er = 2'b00;
      et = 2'b00;
      es = {e >= 9, e >= 7};
      total++;
      if ({kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state} !== {ep, er, et, es}) begin
        bad++;
        $display("FAIL independence edge %0d: got %b, want %b", e,
                 {kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state}, {ep, er, et, es});
      end
    end
    kif.key = 2'b00;
    repeat (12) tick();
  endtask

  task automatic test_reset_mid_hold();
    kif.key = 2'b01;
    for (int e = 1; e <= 25; e++) begin
      tick();
      ep = (e == 7) ? 2'b01 : 2'b00;
      er = 2'b00;
      et = (e == 23) ? 2'b01 : 2'b00;
      es = (e >= 7) ? 2'b01 : 2'b00;
      total++;
      if ({kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state} !== {ep, er, et, es}) begin
        bad++;
        $display("FAIL hold_before_reset edge %0d: got %b, want %b", e,
                 {kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state}, {ep, er, et, es});
      end
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state} !== 8'h00) begin
      bad++;
      $display("FAIL reset_immediate: got %b, want 0",
               {kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state});
    end
    for (int e = 1; e <= 3; e++) begin
      tick();
      total++;
      if ({kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state} !== 8'h00) begin
        bad++;
        $display("FAIL reset_held edge %0d: got %b, want 0", e,
                 {kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state});
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      ep = (e == 7) ? 2'b01 : 2'b00;
      er = 2'b00;
      et = 2'b00;
      es = (e >= 7) ? 2'b01 : 2'b00;
      total++;
      if ({kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state} !== {ep, er, et, es}) begin
        bad++;
        $display("FAIL repress_after_reset edge %0d: got %b, want %b", e,
                 {kif.key_pulse, kif.key_release, kif.key_repeat, kif.key_state}, {ep, er, et, es});
      end
    end
    kif.key = 2'b00;
    repeat (12) tick();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    kif.key = 2'b00;
    test_reset();
    test_glitch();
    test_bounce();
    test_long_press();
    test_independence();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
